mul4_mac_sequencer: RTL and testbench

- Sequential front/back-end stage wrapped around the combinational 4x4 array multiplier.
- Accepts operand pairs over a valid/ready handshake, registers them onto the multiplier inputs, and waits a programmable settle time.
- Samples the 8-bit product and accumulates it. On the operand flagged "last", presents the accumulated sum downstream over a valid/ready handshake.

---
 rtl/mul4_mac_sequencer.sv | 120 ++++++++++++
 tb/tb_mul4_mac_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul4_mac_sequencer.sv
// Operand register, settle timer and accumulator around a 4x4 array multiplier.
// Define MUL4_MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mul4_mac_sequencer #(
  parameter int ACC_W      = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [3:0]       mul_a_q, mul_a_d;
  logic [3:0]       mul_b_q, mul_b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  // One spare bit catches the carry-out of the accumulation.
  assign sum = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, mul_p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          last_d  = in_last;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
`ifdef MUL4_MAC_SATURATE_EN
          if (sum[ACC_W] || ovf_q) begin
            acc_d = '1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d   = ovf_q | sum[ACC_W];
          state_d = last_q ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mul4_mac_sequencer.sv
// Bench for mul4_mac_sequencer: three configurations driven with directed and
// random operand streams, checked against a sum-of-products reference.
module tb_mul4_mac_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid[3];
  logic        in_last[3];
  logic        out_ready[3];
  logic [3:0]  in_a[3];
  logic [3:0]  in_b[3];
  logic [3:0]  mul_a[3];
  logic [3:0]  mul_b[3];
  logic [7:0]  mul_p[3];
  logic        in_ready[3];
  logic        out_valid[3];
  logic        out_ovf[3];
  logic        busy[3];
  logic [15:0] out_acc[3];

  int checks = 0;
  int failures = 0;
  int unsigned prods[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AW = (g == 2) ? 8 : 16;
    localparam int SC = (g == 1) ? 3 : 1;
    logic [AW-1:0] acc;
    assign mul_p[g]   = {4'b0, mul_a[g]} * {4'b0, mul_b[g]};
    assign out_acc[g] = 16'(acc);
    mul4_mac_sequencer #(
      .ACC_W(AW),
      .SETTLE_CYC(SC)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .in_a(in_a[g]),
      .in_b(in_b[g]),
      .in_last(in_last[g]),
      .mul_a(mul_a[g]),
      .mul_b(mul_b[g]),
      .mul_p(mul_p[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_acc(acc),
      .out_ovf(out_ovf[g]),
      .busy(busy[g])
    );
  end

  function automatic int sc(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic int aw(input int k);
    return (k == 2) ? 8 : 16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain sum of all products of the current accumulation.
  task automatic model(input int k, output logic [15:0] acc,
                       output logic ovf);
    longint unsigned sum = 0;
    longint unsigned lim = 64'd1 << aw(k);
    foreach (prods[i]) sum += prods[i];
    ovf = (sum >= lim);
`ifdef MUL4_MAC_SATURATE_EN
    acc = ovf ? 16'(lim - 1) : 16'(sum);
`else
    acc = 16'(sum % lim);
`endif
  endtask

  // Starts and ends just after a falling edge.
  task automatic send(input int k, input logic [3:0] a,
                      input logic [3:0] b, input bit last);
    int n;
    logic [15:0] ea;
    logic eo;
    in_valid[k] = 1'b1;
    in_a[k] = a;
    in_b[k] = b;
    in_last[k] = last;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hs_ready", in_ready[k], 1);
    @(negedge clk);
    in_valid[k] = 1'b0;
    prods.push_back(int'(a) * int'(b));
    chk("mul_a", mul_a[k], a);
    chk("mul_b", mul_b[k], b);
    chk("rdy_low", in_ready[k], 0);
    chk("busy", busy[k], 1);
    n = 1;
    while (!(in_ready[k] || out_valid[k]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, sc(k) + 1);
    if (last) begin
      chk("out_valid_up", out_valid[k], 1);
    end else begin
      chk("rdy_back", in_ready[k], 1);
      model(k, ea, eo);
      chk("partial_acc", out_acc[k], ea);
      chk("partial_ovf", out_ovf[k], eo);
    end
  endtask

  task automatic result(input int k, input int hold);
    logic [15:0] ea;
    logic eo;
    model(k, ea, eo);
    chk("res_valid", out_valid[k], 1);
    chk("res_acc", out_acc[k], ea);
    chk("res_ovf", out_ovf[k], eo);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", out_valid[k], 1);
      chk("hold_acc", out_acc[k], ea);
      chk("hold_ovf", out_ovf[k], eo);
      chk("hold_rdy", in_ready[k], 0);
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    chk("post_valid", out_valid[k], 0);
    chk("post_acc", out_acc[k], 0);
    chk("post_ovf", out_ovf[k], 0);
    chk("post_rdy", in_ready[k], 1);
    chk("post_busy", busy[k], 0);
    out_ready[k] = 1'b0;
    prods.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [15:0] ea;
    logic eo;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      in_last[i] = 1'b0;
      out_ready[i] = 1'b0;
      in_a[i] = 4'd0;
      in_b[i] = 4'd0;
    end

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mul_a", mul_a[i], 0);
      chk("rst_mul_b", mul_b[i], 0);
      chk("rst_acc", out_acc[i], 0);
      chk("rst_ovf", out_ovf[i], 0);
      chk("rst_valid", out_valid[i], 0);
      chk("rst_busy", busy[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("rst_rdy", in_ready[i], 1);

    // Single pair, out_ready held high
    out_ready[0] = 1'b1;
    send(0, 4'd3, 4'd5, 1'b1);
    chk("t1_acc", out_acc[0], 15);
    chk("t1_mul_a", mul_a[0], 3);
    result(0, 0);

    // Three pairs; out_ready high outside HOLD must not disturb the sum
    out_ready[0] = 1'b1;
    send(0, 4'd15, 4'd15, 1'b0);
    send(0, 4'd2, 4'd7, 1'b0);
    send(0, 4'd1, 4'd1, 1'b1);
    chk("t2_acc", out_acc[0], 240);
    result(0, 0);

    // Zero product still counts as a pair
    send(0, 4'd0, 4'd9, 1'b0);
    send(0, 4'd6, 4'd0, 1'b1);
    chk("zero_acc", out_acc[0], 0);
    result(0, 2);

    // Longer settle time
    send(1, 4'd4, 4'd4, 1'b1);
    chk("t3_acc", out_acc[1], 16);
    result(1, 1);

    // 8-bit accumulator overflow
    send(2, 4'd15, 4'd15, 1'b0);
    send(2, 4'd15, 4'd15, 1'b1);
`ifdef MUL4_MAC_SATURATE_EN
    chk("t4_acc", out_acc[2], 255);
`else
    chk("t4_acc", out_acc[2], 194);
`endif
    chk("t4_ovf", out_ovf[2], 1);
    result(2, 0);

    // Backpressure: new pair waits until the result is taken
    send(0, 4'd5, 4'd6, 1'b1);
    in_valid[0] = 1'b1;
    in_a[0] = 4'd9;
    in_b[0] = 4'd9;
    in_last[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid[0], 1);
      chk("bp_acc", out_acc[0], 30);
      chk("bp_rdy", in_ready[0], 0);
      chk("bp_mul_a", mul_a[0], 5);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("bp_rel_valid", out_valid[0], 0);
    chk("bp_rel_rdy", in_ready[0], 1);
    chk("bp_rel_mul_a", mul_a[0], 5);
    chk("bp_rel_acc", out_acc[0], 0);
    prods.delete();
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("bp_take_mul_a", mul_a[0], 9);
    chk("bp_take_rdy", in_ready[0], 0);
    prods.push_back(81);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_lat", n, 1);
    result(0, 0);

    // Reset in the middle of SETTLE
    send(1, 4'd1, 4'd2, 1'b0);
    in_valid[1] = 1'b1;
    in_a[1] = 4'd7;
    in_b[1] = 4'd7;
    in_last[1] = 1'b0;
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy[1], 1);
    rst_n = 1'b0;
    #1;
    chk("arst_mul_a", mul_a[1], 0);
    chk("arst_mul_b", mul_b[1], 0);
    chk("arst_acc", out_acc[1], 0);
    chk("arst_ovf", out_ovf[1], 0);
    chk("arst_valid", out_valid[1], 0);
    chk("arst_busy", busy[1], 0);
    prods.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rdy", in_ready[1], 1);
    send(1, 4'd2, 4'd3, 1'b1);
    chk("arst_acc6", out_acc[1], 6);
    result(1, 0);

    // Random accumulations on every configuration
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 6; t++) begin
        n = $urandom_range(1, 4);
        for (int p = 0; p < n; p++) begin
          send(k, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               (p == n - 1));
        end
        result(k, $urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
